// File: rtl/rv64g_l1_refill_sequencer.sv
// L1 line eviction/refill sequencer: optional 8-beat writeback of the victim, 8-beat refill
// into the banked data arrays, then one broadcast tag/state write.
module rv64g_l1_refill_sequencer #(
    parameter int TAG_W   = 53,
    parameter int INDEX_W = 5,
    parameter int WORDS   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               evict_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [2:0]         way_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [1:0]         state_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [63:0]        wb_data_o,
    output logic [2:0]         wb_beat_o,
    input  logic               fill_valid_i,
    output logic               fill_ready_o,
    input  logic [63:0]        fill_data_i,
    output logic               arr_req_o,
    output logic               arr_we_o,
    output logic               arr_tag_we_o,
    output logic               arr_tag_broadcast_o,
    output logic [INDEX_W-1:0] arr_index_o,
    output logic [2:0]         arr_word_o,
    output logic [2:0]         arr_way_o,
    output logic [7:0]         arr_be_o,
    output logic [63:0]        arr_wdata_o,
    output logic [TAG_W-1:0]   arr_tag_o,
    output logic [1:0]         arr_state_o,
    input  logic [63:0]        arr_rdata_i
);
    localparam logic [2:0] LAST = 3'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, EV_RD, EV_CAP, EV_WB, FILL, TAG, DONE} seq_state_t;

    seq_state_t         state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic [INDEX_W-1:0] lat_index;
    logic [2:0]         lat_way;
    logic [TAG_W-1:0]   lat_tag;
    logic [1:0]         lat_state;
    logic [63:0]        hold;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_index <= '0;
            lat_way   <= '0;
            lat_tag   <= '0;
            lat_state <= '0;
            hold      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start_i) begin
                lat_index <= index_i;
                lat_way   <= way_i;
                lat_tag   <= tag_i;
                lat_state <= state_i;
            end
            // Array read data arrives one cycle after the EV_RD request.
            if (state == EV_CAP) hold <= arr_rdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:   if (start_i) state_nxt = evict_i ? EV_RD : FILL;
            EV_RD:  state_nxt = EV_CAP;
            EV_CAP: state_nxt = EV_WB;
            EV_WB: if (wb_ready_i) begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end else begin
                    cnt_nxt   = cnt + 3'd1;
                    state_nxt = EV_RD;
                end
            end
            FILL: if (fill_valid_i) begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = TAG;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            TAG:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o              = (state != IDLE);
        done_o              = 1'b0;
        wb_valid_o          = 1'b0;
        wb_data_o           = '0;
        wb_beat_o           = '0;
        fill_ready_o        = 1'b0;
        arr_req_o           = 1'b0;
        arr_we_o            = 1'b0;
        arr_tag_we_o        = 1'b0;
        arr_tag_broadcast_o = 1'b0;
        arr_index_o         = '0;
        arr_word_o          = '0;
        arr_way_o           = '0;
        arr_be_o            = '0;
        arr_wdata_o         = '0;
        arr_tag_o           = '0;
        arr_state_o         = '0;
        case (state)
            EV_RD: begin
                arr_req_o   = 1'b1;
                arr_index_o = lat_index;
                arr_way_o   = lat_way;
                arr_word_o  = cnt;
            end
            EV_WB: begin
                wb_valid_o = 1'b1;
                wb_data_o  = hold;
                wb_beat_o  = cnt;
            end
            FILL: begin
                fill_ready_o = 1'b1;
                if (fill_valid_i) begin
                    arr_req_o   = 1'b1;
                    arr_we_o    = 1'b1;
                    arr_be_o    = 8'hFF;
                    arr_index_o = lat_index;
                    arr_way_o   = lat_way;
                    arr_word_o  = cnt;
                    arr_wdata_o = fill_data_i;
                end
            end
            TAG: begin
                arr_req_o           = 1'b1;
                arr_tag_we_o        = 1'b1;
                arr_tag_broadcast_o = 1'b1;
                arr_index_o         = lat_index;
                arr_way_o           = lat_way;
                arr_tag_o           = lat_tag;
                arr_state_o         = lat_state;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rv64g_l1_refill_sequencer.sv
// Randomized bench for the refill sequencer: an ordered queue of expected array/writeback/done
// events per operation, consumed by a monitor that observes the DUT every cycle.
module tb_rv64g_l1_refill_sequencer;
    localparam int TAG_W = 53;
    localparam int INDEX_W = 5;
    localparam logic [2:0] K_RD = 3'd1, K_WB = 3'd2, K_WR = 3'd3, K_TG = 3'd4, K_DN = 3'd5;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic start_i = 0, evict_i = 0, wb_ready_i = 0, fill_valid_i = 0;
    logic [INDEX_W-1:0] index_i = '0;
    logic [2:0] way_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic [1:0] state_i = '0;
    logic [63:0] fill_data_i = '0, arr_rdata_i;
    logic busy_o, done_o, wb_valid_o, fill_ready_o;
    logic [63:0] wb_data_o, arr_wdata_o;
    logic [2:0] wb_beat_o, arr_word_o, arr_way_o;
    logic arr_req_o, arr_we_o, arr_tag_we_o, arr_tag_broadcast_o;
    logic [INDEX_W-1:0] arr_index_o;
    logic [7:0] arr_be_o;
    logic [TAG_W-1:0] arr_tag_o;
    logic [1:0] arr_state_o;

    rv64g_l1_refill_sequencer #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WORDS(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .evict_i(evict_i),
        .index_i(index_i), .way_i(way_i), .tag_i(tag_i), .state_i(state_i),
        .busy_o(busy_o), .done_o(done_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o), .wb_beat_o(wb_beat_o),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data_i),
        .arr_req_o(arr_req_o), .arr_we_o(arr_we_o), .arr_tag_we_o(arr_tag_we_o),
        .arr_tag_broadcast_o(arr_tag_broadcast_o), .arr_index_o(arr_index_o), .arr_word_o(arr_word_o),
        .arr_way_o(arr_way_o), .arr_be_o(arr_be_o), .arr_wdata_o(arr_wdata_o), .arr_tag_o(arr_tag_o),
        .arr_state_o(arr_state_o), .arr_rdata_i(arr_rdata_i)
    );

    typedef struct packed {
        logic [2:0] kind; logic req; logic [4:0] idx; logic [2:0] way; logic [2:0] word;
        logic [7:0] be; logic bc; logic [63:0] data; logic [52:0] tag; logic [1:0] st;
    } ev_t;

    ev_t expq[$];
    int n_cmp = 0, n_bad = 0;
    logic [63:0] ref_mem [32][8][8];

    function automatic logic [63:0] seed_word(int i, int j, int k);
        return 64'hDEAD_0000_0000_0000 | 64'(i << 16) | 64'(j << 8) | 64'(k);
    endfunction

    function automatic ev_t mk(logic [2:0] kind, logic req, logic [4:0] idx, logic [2:0] way,
                               logic [2:0] word, logic [7:0] be, logic bc, logic [63:0] data,
                               logic [52:0] tag, logic [1:0] st);
        return {kind, req, idx, way, word, be, bc, data, tag, st};
    endfunction

    task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic take(ev_t got);
        ev_t e;
        if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got %0h expected no event", got);
        end else begin
            e = expq.pop_front();
            chk("event_order", got, e);
        end
    endtask

    // Array model: the bench is the banked L1 data array behind the scalar port.
    logic [63:0] arr_mem [32][8][8];
    bit mem_init = 0;
    logic pl_en = 0;
    logic [4:0] pl_idx = '0;
    logic [2:0] pl_way = '0;
    logic [63:0] pl_base = '0;
    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++)
                arr_mem[i][j][k] = seed_word(i, j, k);
            mem_init = 1;
        end
        if (pl_en) for (int k = 0; k < 8; k++) arr_mem[pl_idx][pl_way][k] = pl_base + 64'(k);
        if (arr_req_o && arr_we_o) arr_mem[arr_index_o][arr_way_o][arr_word_o] = arr_wdata_o;
        arr_rdata_i <= (arr_req_o && !arr_we_o && !arr_tag_we_o)
                       ? arr_mem[arr_index_o][arr_way_o][arr_word_o] : {$urandom, $urandom};
    end

    logic stall_prev = 0;
    logic [63:0] stall_data = '0;
    always @(negedge clk_i) begin
        if (rst_i) stall_prev = 0;
        else begin
            chk("busy", busy_o, expq.size() != 0);
            if (stall_prev && wb_valid_o) chk("wb_data_stable", wb_data_o, stall_data);
            stall_prev = wb_valid_o && !wb_ready_i;
            stall_data = wb_data_o;
            if (arr_req_o && !arr_we_o && !arr_tag_we_o)
                take(mk(K_RD, 1, arr_index_o, arr_way_o, arr_word_o, arr_be_o, arr_tag_broadcast_o,
                        arr_wdata_o, arr_tag_o, arr_state_o));
            if (arr_we_o)
                take(mk(K_WR, arr_req_o, arr_index_o, arr_way_o, arr_word_o, arr_be_o,
                        arr_tag_broadcast_o, arr_wdata_o, arr_tag_o, arr_state_o));
            if (arr_tag_we_o)
                take(mk(K_TG, arr_req_o, arr_index_o, arr_way_o, arr_word_o, arr_be_o,
                        arr_tag_broadcast_o, arr_wdata_o, arr_tag_o, arr_state_o));
            if (wb_valid_o && wb_ready_i) take(mk(K_WB, 0, 0, 0, wb_beat_o, 0, 0, wb_data_o, 0, 0));
            if (done_o) take(mk(K_DN, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    end

    task automatic preload(logic [4:0] idx, logic [2:0] way, logic [63:0] base);
        pl_en = 1; pl_idx = idx; pl_way = way; pl_base = base;
        @(posedge clk_i); #1;
        pl_en = 0;
        for (int k = 0; k < 8; k++) ref_mem[idx][way][k] = base + 64'(k);
    endtask

    task automatic push_op(bit ev, logic [4:0] idx, logic [2:0] way, logic [52:0] tag,
                           logic [1:0] st, logic [63:0] fbase);
        if (ev) for (int k = 0; k < 8; k++) begin
            expq.push_back(mk(K_RD, 1, idx, way, 3'(k), 0, 0, 0, 0, 0));
            expq.push_back(mk(K_WB, 0, 0, 0, 3'(k), 0, 0, ref_mem[idx][way][k], 0, 0));
        end
        for (int k = 0; k < 8; k++)
            expq.push_back(mk(K_WR, 1, idx, way, 3'(k), 8'hFF, 0, fbase + 64'(k), 0, 0));
        expq.push_back(mk(K_TG, 1, idx, way, 0, 0, 1, 0, tag, st));
        expq.push_back(mk(K_DN, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic drive_start(bit ev, logic [4:0] idx, logic [2:0] way, logic [52:0] tag, logic [1:0] st);
        start_i = 1; evict_i = ev; index_i = idx; way_i = way; tag_i = tag; state_i = st;
        fill_valid_i = 0; wb_ready_i = 0;
        @(posedge clk_i); #1;
        start_i = 0;
    endtask

    // mode 0: always ready/valid; 1: 5-cycle stall on wb beat 3 and 2-cycle fill gaps; 2: random
    task automatic run_op(bit ev, logic [4:0] idx, logic [2:0] way, logic [52:0] tag, logic [1:0] st,
                          logic [63:0] fbase, int mode, int exp_cyc);
        int fk = 0, hold = 0, gap = 0, cyc = 0;
        drive_start(ev, idx, way, tag, st);
        push_op(ev, idx, way, tag, st, fbase);
        forever begin
            start_i = 1'($urandom); evict_i = 1'($urandom); index_i = 5'($urandom);
            way_i = 3'($urandom); tag_i = {$urandom, $urandom}; state_i = 2'($urandom);
            fill_data_i = fbase + 64'(fk);
            case (mode)
                0: begin fill_valid_i = 1; wb_ready_i = 1; end
                1: begin
                    fill_valid_i = (gap == 0);
                    wb_ready_i = !(wb_valid_o && wb_beat_o == 3'd3 && hold < 5);
                end
                default: begin
                    fill_valid_i = ($urandom_range(0, 3) != 0);
                    wb_ready_i = ($urandom_range(0, 2) != 0);
                end
            endcase
            @(negedge clk_i); #1;
            cyc++;
            if (fill_valid_i && fill_ready_o) begin fk++; gap = 2; end
            else if (gap > 0) gap--;
            if (wb_valid_o && wb_beat_o == 3'd3 && !wb_ready_i) hold++;
            if (expq.size() == 0) break;
            if (cyc > 400) begin
                n_cmp++; n_bad++;
                $display("FAIL op_timeout: got %0d events outstanding expected 0", expq.size());
                expq.delete();
                rst_i = 1; @(posedge clk_i); #1; rst_i = 0;
                break;
            end
            @(posedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        start_i = 0; fill_valid_i = 0; wb_ready_i = 0;
        if (exp_cyc > 0) chk("op_latency", 32'(cyc), 32'(exp_cyc));
        for (int k = 0; k < 8; k++) ref_mem[idx][way][k] = fbase + 64'(k);
    endtask

    task automatic reset_mid_fill(logic [4:0] idx, logic [2:0] way, logic [63:0] fbase);
        int fk = 0;
        drive_start(0, idx, way, 53'h1234, 2'd2);
        push_op(0, idx, way, 53'h1234, 2'd2, fbase);
        for (int n = 0; n < 30; n++) begin
            fill_valid_i = 1; fill_data_i = fbase + 64'(fk);
            @(negedge clk_i); #1;
            if (fill_valid_i && fill_ready_o) fk++;
            if (expq.size() <= 6) break;
            @(posedge clk_i); #1;
        end
        chk("beats_before_reset", 32'(fk), 32'd4);
        @(posedge clk_i); #1;
        fill_data_i = fbase + 64'(fk);
        #1 rst_i = 1;
        #1;
        chk("reset_outputs_zero", {busy_o, done_o, wb_valid_o, fill_ready_o, arr_req_o, arr_we_o,
            arr_tag_we_o, arr_tag_broadcast_o, arr_index_o, arr_word_o, arr_way_o, arr_be_o,
            arr_wdata_o, arr_tag_o, arr_state_o, wb_data_o, wb_beat_o}, '0);
        expq.delete();
        fill_valid_i = 0;
        for (int k = 0; k < 4; k++) ref_mem[idx][way][k] = fbase + 64'(k);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        repeat (5) @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++)
            ref_mem[i][j][k] = seed_word(i, j, k);
        #3;
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_outputs", {wb_valid_o, fill_ready_o, arr_req_o, arr_we_o, arr_tag_we_o,
                              arr_tag_broadcast_o, arr_be_o, arr_wdata_o, wb_data_o}, '0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        @(posedge clk_i); #1;
        run_op(0, 5'd5, 3'd3, 53'h1F_0000_ABCD_0001, 2'd3, 64'h1000, 0, 10);
        preload(5'd2, 3'd1, 64'hA0);
        run_op(1, 5'd2, 3'd1, 53'h0A_5555_0000_0002, 2'd1, 64'h2000, 0, 34);
        preload(5'd2, 3'd1, 64'hA0);
        run_op(1, 5'd2, 3'd1, 53'h00_0000_0000_0003, 2'd2, 64'h3000, 1, 0);
        reset_mid_fill(5'd9, 3'd6, 64'h4000);
        run_op(1, 5'd9, 3'd6, 53'h1F_FFFF_FFFF_FFFF, 2'd0, 64'h5000, 0, 34);
        for (int n = 0; n < 20; n++)
            run_op(1'($urandom), 5'($urandom), 3'($urandom), {$urandom, $urandom}, 2'($urandom),
                   {$urandom, $urandom}, 2, 0);
        repeat (5) @(posedge clk_i);
        #1;
        chk("final_queue_empty", 32'(expq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
